// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-requester round-robin sequencer for a shared 8-bit logic unit
module logic_unit_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_x,
    input  logic [7:0] req0_y,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_x,
    input  logic [7:0] req1_y,
    output logic [7:0] lu_x,
    output logic [7:0] lu_y,
    output logic [1:0] lu_op,
    input  logic [7:0] lu_o,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_ptr;
    logic       r_id;
    logic [7:0] r_lu_x;
    logic [7:0] r_lu_y;
    logic [1:0] r_lu_op;
    logic [7:0] r_rsp_data;
    logic       r_rsp_zero;

    logic       w_grant_valid;
    logic       w_grant_id;
    logic       w_handshake;
    logic [7:0] w_sel_x;
    logic [7:0] w_sel_y;
    logic [1:0] w_sel_op;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        w_grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = r_ptr;
        end else begin
            w_grant_id = req1_valid;
        end
        w_sel_x  = w_grant_id ? req1_x  : req0_x;
        w_sel_y  = w_grant_id ? req1_y  : req0_y;
        w_sel_op = w_grant_id ? req1_op : req0_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_handshake  = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst && w_grant_valid) begin
                    w_handshake  = 1'b1;
                    req0_ready   = ~w_grant_id;
                    req1_ready   = w_grant_id;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: w_next_state = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= 1'b0;
            r_id       <= 1'b0;
            r_lu_x     <= 8'h00;
            r_lu_y     <= 8'h00;
            r_lu_op    <= 2'b00;
            r_rsp_data <= 8'h00;
            r_rsp_zero <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_lu_x  <= w_sel_x;
                r_lu_y  <= w_sel_y;
                r_lu_op <= w_sel_op;
                r_id    <= w_grant_id;
                r_ptr   <= ~w_grant_id;
            end
            // lu_o is only trusted one cycle after the operands settle.
            if (r_state == S_EXEC) begin
                r_rsp_data <= lu_o;
                r_rsp_zero <= (lu_o == 8'h00);
            end
        end
    end

    assign lu_x      = r_lu_x;
    assign lu_y      = r_lu_y;
    assign lu_op     = r_lu_op;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - directed self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic       req0_ready;
    logic [1:0] req0_op;
    logic [7:0] req0_x;
    logic [7:0] req0_y;
    logic       req1_valid;
    logic       req1_ready;
    logic [1:0] req1_op;
    logic [7:0] req1_x;
    logic [7:0] req1_y;
    logic [7:0] lu_x;
    logic [7:0] lu_y;
    logic [1:0] lu_op;
    logic [7:0] lu_o;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       busy;

    int checks;
    int failures;

    logic_unit_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .lu_x       (lu_x),
        .lu_y       (lu_y),
        .lu_op      (lu_op),
        .lu_o       (lu_o),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    // Shared combinational logic unit.
    always_comb begin
        case (lu_op)
            2'b00:   lu_o = lu_x & lu_y;
            2'b01:   lu_o = lu_x | lu_y;
            2'b10:   lu_o = lu_x ^ lu_y;
            default: lu_o = ~lu_x;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"},      {7'd0, busy},       8'h00);
        chk({tag, "_rsp_valid"}, {7'd0, rsp_valid},  8'h00);
        chk({tag, "_rsp_id"},    {7'd0, rsp_id},     8'h00);
        chk({tag, "_rsp_data"},  rsp_data,           8'h00);
        chk({tag, "_rsp_zero"},  {7'd0, rsp_zero},   8'h00);
        chk({tag, "_lu_x"},      lu_x,               8'h00);
        chk({tag, "_lu_y"},      lu_y,               8'h00);
        chk({tag, "_lu_op"},     {6'd0, lu_op},      8'h00);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_op    = 2'b00;
        req0_x     = 8'h00;
        req0_y     = 8'h00;
        req1_valid = 1'b1;
        req1_op    = 2'b00;
        req1_x     = 8'h00;
        req1_y     = 8'h00;

        // Reset state, with requests pending while rst is high.
        next_cycle(); #1;
        chk_reset_values("reset");
        chk("reset_req0_ready", {7'd0, req0_ready}, 8'h00);
        chk("reset_req1_ready", {7'd0, req1_ready}, 8'h00);
        next_cycle();

        // Single AND from req0.
        rst = 1'b0; req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_x = 8'hF0; req0_y = 8'h3C;
        #1;
        chk("and_req0_ready", {7'd0, req0_ready}, 8'h01);
        chk("and_req1_ready", {7'd0, req1_ready}, 8'h00);
        next_cycle(); req0_valid = 1'b0; #1;
        chk("and_busy", {7'd0, busy}, 8'h01);
        chk("and_lu_x", lu_x, 8'hF0);
        chk("and_lu_y", lu_y, 8'h3C);
        chk("and_lu_op", {6'd0, lu_op}, 8'h00);
        chk("and_rsp_valid_exec", {7'd0, rsp_valid}, 8'h00);
        next_cycle(); #1;
        chk("and_rsp_valid", {7'd0, rsp_valid}, 8'h01);
        chk("and_rsp_id", {7'd0, rsp_id}, 8'h00);
        chk("and_rsp_data", rsp_data, 8'h30);
        chk("and_rsp_zero", {7'd0, rsp_zero}, 8'h00);
        rsp_ready = 1'b1;
        next_cycle(); rsp_ready = 1'b0; #1;
        chk("and_busy_done", {7'd0, busy}, 8'h00);
        chk("and_rsp_valid_done", {7'd0, rsp_valid}, 8'h00);

        // NOT from req1, then backpressure in RESP.
        req1_valid = 1'b1; req1_op = 2'b11; req1_x = 8'h5A; req1_y = 8'hFF;
        #1;
        chk("not_req1_ready", {7'd0, req1_ready}, 8'h01);
        chk("not_req0_ready", {7'd0, req0_ready}, 8'h00);
        next_cycle(); req1_valid = 1'b0;
        next_cycle(); #1;
        chk("not_rsp_valid", {7'd0, rsp_valid}, 8'h01);
        chk("not_rsp_id", {7'd0, rsp_id}, 8'h01);
        chk("not_rsp_data", rsp_data, 8'hA5);
        chk("not_rsp_zero", {7'd0, rsp_zero}, 8'h00);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle(); #1;
            chk("bp_rsp_data", rsp_data, 8'hA5);
            chk("bp_rsp_valid", {7'd0, rsp_valid}, 8'h01);
            chk("bp_req0_ready", {7'd0, req0_ready}, 8'h00);
            chk("bp_req1_ready", {7'd0, req1_ready}, 8'h00);
            chk("bp_busy", {7'd0, busy}, 8'h01);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        next_cycle(); rsp_ready = 1'b0; #1;
        chk("bp_release_rsp_valid", {7'd0, rsp_valid}, 8'h00);
        chk("bp_release_busy", {7'd0, busy}, 8'h00);

        // Drop before grant: req1 pulses while busy; ptr stays at 1 after req0's grant.
        req0_valid = 1'b1; req0_op = 2'b01; req0_x = 8'h0F; req0_y = 8'hF0;
        #1;
        chk("drop_req0_ready", {7'd0, req0_ready}, 8'h01);
        next_cycle(); req0_valid = 1'b0; req1_valid = 1'b1;
        req1_op = 2'b10; req1_x = 8'h0F; req1_y = 8'h0F;
        #1;
        chk("drop_req1_ready_busy", {7'd0, req1_ready}, 8'h00);
        next_cycle(); req1_valid = 1'b0; #1;
        chk("drop_rsp_id", {7'd0, rsp_id}, 8'h00);
        chk("drop_rsp_data", rsp_data, 8'hFF);
        rsp_ready = 1'b1;
        next_cycle(); rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_x = 8'hFF; req0_y = 8'h0F;
        req1_valid = 1'b1;
        #1;
        chk("drop_tie_req1_ready", {7'd0, req1_ready}, 8'h01);
        chk("drop_tie_req0_ready", {7'd0, req0_ready}, 8'h00);
        next_cycle(); req0_valid = 1'b0; req1_valid = 1'b0;
        next_cycle(); #1;
        chk("drop_tie_rsp_id", {7'd0, rsp_id}, 8'h01);
        chk("drop_tie_rsp_data", rsp_data, 8'h00);
        chk("drop_tie_rsp_zero", {7'd0, rsp_zero}, 8'h01);
        rsp_ready = 1'b1;
        next_cycle(); rsp_ready = 1'b0;

        // Reset during EXEC; grant to req0 leaves ptr=1 unless reset clears it.
        req0_valid = 1'b1; req0_op = 2'b00; req0_x = 8'hF0; req0_y = 8'h3C;
        #1;
        chk("rexec_req0_ready", {7'd0, req0_ready}, 8'h01);
        next_cycle(); req0_valid = 1'b0; rst = 1'b1;
        next_cycle(); rst = 1'b0; #1;
        chk_reset_values("rexec");
        next_cycle(); #1;
        chk("rexec_no_rsp", {7'd0, rsp_valid}, 8'h00);
        req0_valid = 1'b1; req0_op = 2'b01; req0_x = 8'h0F; req0_y = 8'hF0;
        req1_valid = 1'b1; req1_op = 2'b10; req1_x = 8'hAA; req1_y = 8'hAA;
        #1;
        chk("rexec_tie_req0_ready", {7'd0, req0_ready}, 8'h01);
        chk("rexec_tie_req1_ready", {7'd0, req1_ready}, 8'h00);

        // Reset during RESP.
        next_cycle(); req0_valid = 1'b0; req1_valid = 1'b0;
        next_cycle(); #1;
        chk("rresp_rsp_valid", {7'd0, rsp_valid}, 8'h01);
        rst = 1'b1;
        next_cycle(); rst = 1'b0; #1;
        chk_reset_values("rresp");

        // Continuous contention: grants alternate 0,1,0.
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("cont_req0_ready", {7'd0, req0_ready}, (k % 2 == 0) ? 8'h01 : 8'h00);
            chk("cont_req1_ready", {7'd0, req1_ready}, (k % 2 == 1) ? 8'h01 : 8'h00);
            next_cycle();
            next_cycle(); #1;
            chk("cont_rsp_valid", {7'd0, rsp_valid}, 8'h01);
            chk("cont_rsp_id", {7'd0, rsp_id}, (k % 2 == 1) ? 8'h01 : 8'h00);
            chk("cont_rsp_data", rsp_data, (k % 2 == 1) ? 8'h00 : 8'hFF);
            chk("cont_rsp_zero", {7'd0, rsp_zero}, (k % 2 == 1) ? 8'h01 : 8'h00);
            next_cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Sequencer and round-robin arbiter that shares one 8-bit combinational logic unit (bitwise AND/OR/XOR/NOT) between two requesters. It accepts one operation at a time through a valid/ready handshake, drives registered operands and opcode to the logic unit, captures the result and returns it with the requester ID and a zero flag. It sits between the ALU front-end requesters and the bitwise logic datapath.

## Interface
- No parameters. Data width is fixed at 8, requester count is fixed at 2.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  requester n has an operation pending
- req0_ready / req1_ready  output  1  requester n's operation accepted this cycle
- req0_op / req1_op  input  2  00=AND, 01=OR, 10=XOR, 11=NOT x (y ignored)
- req0_x / req1_x  input  8  operand x
- req0_y / req1_y  input  8  operand y
- lu_x  output  8  operand x to logic unit (registered)
- lu_y  output  8  operand y to logic unit (registered)
- lu_op  output  2  opcode to logic unit (registered)
- lu_o  input  8  logic unit result (combinational from lu_x/lu_y/lu_op)
- rsp_valid  output  1  response held
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the op
- rsp_data  output  8  result
- rsp_zero  output  1  rsp_data == 8'h00
- busy  output  1  state != IDLE

## Operation
- FSM states:
  - IDLE: grant logic active.
  - EXEC: logic unit evaluating.
  - RESP: result held for the consumer.
- IDLE:
  - Grant is combinational. With only one req valid, that requester is granted. With both valid, the requester selected by priority pointer `ptr` is granted.
  - Only the granted requester sees reqN_ready=1, in the same cycle as its valid. The handshake completes that cycle.
  - On handshake: latch x, y, op into lu_x/lu_y/lu_op and latch the grant ID. Set `ptr` to the non-granted requester. Go to EXEC.
- EXEC: unconditional, one cycle. Capture lu_o into rsp_data, compute rsp_zero, go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_zero stay stable while rsp_ready=0.
  - On rsp_ready=1: go to IDLE.
  - No new request is accepted in RESP. Both reqN_ready are 0 outside IDLE.
- NOT op: lu_y is still loaded from the request but the logic unit ignores it. rsp_zero is computed on the NOT result.
- Requester signals are ignored outside IDLE. A requester may drop valid before it is granted.
- ptr changes only on a grant, never on an idle cycle.

## Timing
- Reset values:
  - state=IDLE, ptr=0.
  - lu_x=lu_y=8'h00, lu_op=2'b00.
  - rsp_valid=0, rsp_id=0, rsp_data=8'h00, rsp_zero=0.
  - busy=0, req0_ready=req1_ready=0 (while rst is high).
- Latency, with the handshake at cycle N:
  - lu_* valid from N+1.
  - rsp_valid=1 from N+2.
  - If rsp_ready is held high: back in IDLE at N+3, next grant possible at N+3.
  - Minimum issue interval is 3 cycles.
- Simultaneous requests: strict alternation under continuous contention, 0,1,0,1,...
- rsp_ready while rsp_valid=0 has no effect.
- Reset mid-operation (EXEC or RESP):
  - Next cycle is IDLE with all reset values.
  - The in-flight op is discarded and no response is produced.
  - ptr returns to 0.
- lu_o is sampled only at the end of EXEC. Changes on lu_o in other states are ignored.

## Test plan
- Single AND: req0 valid, op=00, x=8'hF0, y=8'h3C.
  - req0_ready=1 at cycle N.
  - rsp at N+2: rsp_id=0, rsp_data=8'h30, rsp_zero=0.
  - rsp_ready=1 returns busy=0 at N+3.
- Contention: both valid continuously after reset; req0 OR 8'h0F,8'hF0; req1 XOR 8'hAA,8'hAA.
  - Grant order is 0,1,0.
  - Responses: id0 data=8'hFF zero=0; id1 data=8'h00 zero=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_data is stable, reqN_ready=0 throughout, busy=1.
  - A single cycle of rsp_ready=1 leaves RESP and rsp_valid=0 on the next cycle.
- NOT op: req1 op=11, x=8'h5A, y=8'hFF → rsp_id=1, rsp_data=8'hA5, rsp_zero=0.
- Reset in EXEC and in RESP: assert rst for 1 cycle.
  - All outputs return to reset values and no rsp_valid appears.
  - A subsequent simultaneous request is granted to req0 (ptr=0).
- Drop before grant: req1 valid for 1 cycle while busy, then deasserts → no req1 grant, ptr unchanged.
